dbg_io_responder: RTL and testbench



---
 rtl/dbg_io_responder.sv | 164 ++++++++++++++++
 tb/tb_dbg_io_responder.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dbg_io_responder.sv
// Debug I/O window responder on the membus.
// Write decode: a tagged word prints one character, an odd word requests exit,
// anything else is acknowledged and dropped. Reads pop the input character
// queue, returning 0 when it is empty.
// Output characters leave through a paced valid/ready stream. exit_valid is
// held back until every queued output character has been handed off.
//
// Handshake rules:
// - membus request: accepted on a cycle where s_valid && s_ready.
//   s_ready does not depend on s_valid.
// - membus response: s_rvalid pulses exactly one cycle after each accept.
// - tx stream: a character moves when tx_valid && tx_ready. tx_data holds
//   steady while tx_valid && !tx_ready.
// - rx stream: a character moves when rx_valid && rx_ready.
module dbg_io_responder #(
   parameter int DATA_WIDTH = 64,
   parameter int ADDR_WIDTH = 64,
   parameter int TX_DEPTH   = 8,
   parameter int RX_DEPTH   = 4,
   parameter int TX_DIV     = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    s_valid,
   output logic                    s_ready,
   input  logic [ADDR_WIDTH-1:0]   s_addr,
   input  logic                    s_wen,
   input  logic [DATA_WIDTH-1:0]   s_wdata,
   input  logic [DATA_WIDTH/8-1:0] s_wmask,
   output logic                    s_rvalid,
   output logic [DATA_WIDTH-1:0]   s_rdata,
   output logic                    tx_valid,
   output logic [7:0]              tx_data,
   input  logic                    tx_ready,
   input  logic                    rx_valid,
   input  logic [7:0]              rx_data,
   output logic                    rx_ready,
   output logic                    exit_valid,
   output logic [DATA_WIDTH-1:0]   exit_code
);

   localparam int TXAW = $clog2(TX_DEPTH);
   localparam int TXPW = TXAW + 1;
   localparam int RXAW = $clog2(RX_DEPTH);
   localparam int RXPW = RXAW + 1;
   localparam int PCW  = (TX_DIV > 1) ? $clog2(TX_DIV) : 1;
   localparam logic [19:0] PRINT_TAG = 20'h01010;

   // Storage and pointers. Pointers carry one extra wrap bit so that the
   // full and empty states can be told apart.
   logic [7:0]            tx_mem_q [TX_DEPTH];
   logic [7:0]            rx_mem_q [RX_DEPTH];
   logic [TXPW-1:0]       tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
   logic [RXPW-1:0]       rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
   logic [PCW-1:0]        pace_q, pace_d;
   logic                  exit_pend_q, exit_pend_d;
   logic                  exit_valid_q, exit_valid_d;
   logic [DATA_WIDTH-1:0] exit_code_q, exit_code_d;
   logic                  rvalid_q, rvalid_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

   logic tx_empty, tx_full, rx_empty, rx_full;
   logic accept, is_print, tx_push, tx_pop, exit_set, rx_push, rx_pop;
   logic unused_ok;

   // Address and byte mask carry no information: the window is decoded upstream.
   assign unused_ok = ^{s_addr, s_wmask};

   assign tx_empty = (tx_wr_q == tx_rd_q);
   assign tx_full  = (tx_wr_q[TXPW-1] != tx_rd_q[TXPW-1]) &&
                     (tx_wr_q[TXAW-1:0] == tx_rd_q[TXAW-1:0]);
   assign rx_empty = (rx_wr_q == rx_rd_q);
   assign rx_full  = (rx_wr_q[RXPW-1] != rx_rd_q[RXPW-1]) &&
                     (rx_wr_q[RXAW-1:0] == rx_rd_q[RXAW-1:0]);

   assign s_ready  = !tx_full && !exit_pend_q;
   assign accept   = s_valid && s_ready;
   assign is_print = (s_wdata[DATA_WIDTH-1 -: 20] == PRINT_TAG);
   assign tx_push  = accept && s_wen && is_print;
   assign exit_set = accept && s_wen && !is_print && s_wdata[0];
   assign rx_pop   = accept && !s_wen && !rx_empty;

   assign tx_valid = !tx_empty && (pace_q == '0);
   assign tx_data  = tx_mem_q[tx_rd_q[TXAW-1:0]];
   assign tx_pop   = tx_valid && tx_ready;

   assign rx_ready = !rx_full;
   assign rx_push  = rx_valid && rx_ready;

   // Exit reports once the output queue has drained. Characters already
   // handed off count as complete.
   assign exit_valid = exit_valid_q || (exit_pend_q && tx_empty);
   assign exit_code  = exit_code_q;
   assign s_rvalid   = rvalid_q;
   assign s_rdata    = rdata_q;

   // Next-state logic for pointers, pacing, exit latch and the response.
   always_comb begin
      tx_wr_d      = tx_wr_q;
      tx_rd_d      = tx_rd_q;
      rx_wr_d      = rx_wr_q;
      rx_rd_d      = rx_rd_q;
      pace_d       = pace_q;
      exit_pend_d  = exit_pend_q;
      exit_valid_d = exit_valid;
      exit_code_d  = exit_code_q;
      rvalid_d     = accept;
      rdata_d      = '0;

      if (tx_push) tx_wr_d = tx_wr_q + TXPW'(1);
      if (tx_pop)  tx_rd_d = tx_rd_q + TXPW'(1);
      if (rx_push) rx_wr_d = rx_wr_q + RXPW'(1);
      if (rx_pop) begin
         rx_rd_d = rx_rd_q + RXPW'(1);
         rdata_d = {{(DATA_WIDTH-8){1'b0}}, rx_mem_q[rx_rd_q[RXAW-1:0]]};
      end

      // After a handshake, wait TX_DIV-1 idle cycles before the next one.
      if (tx_pop) begin
         pace_d = PCW'(TX_DIV - 1);
      end else if (pace_q != '0) begin
         pace_d = pace_q - PCW'(1);
      end

      if (exit_set) begin
         exit_pend_d = 1'b1;
         exit_code_d = s_wdata;
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         tx_wr_q      <= '0;
         tx_rd_q      <= '0;
         rx_wr_q      <= '0;
         rx_rd_q      <= '0;
         pace_q       <= '0;
         exit_pend_q  <= 1'b0;
         exit_valid_q <= 1'b0;
         exit_code_q  <= '0;
         rvalid_q     <= 1'b0;
         rdata_q      <= '0;
      end else begin
         tx_wr_q      <= tx_wr_d;
         tx_rd_q      <= tx_rd_d;
         rx_wr_q      <= rx_wr_d;
         rx_rd_q      <= rx_rd_d;
         pace_q       <= pace_d;
         exit_pend_q  <= exit_pend_d;
         exit_valid_q <= exit_valid_d;
         exit_code_q  <= exit_code_d;
         rvalid_q     <= rvalid_d;
         rdata_q      <= rdata_d;
      end
   end

   // Character storage. It needs no reset because the pointers define validity.
   always_ff @(posedge clk) begin
      if (tx_push) tx_mem_q[tx_wr_q[TXAW-1:0]] <= s_wdata[7:0];
      if (rx_push) rx_mem_q[rx_wr_q[RXAW-1:0]] <= rx_data;
   end

endmodule

// File: tb/tb_dbg_io_responder.sv
// Bench for dbg_io_responder. A queue-based reference model is advanced on
// every rising edge. Every DUT output is compared against the model on every
// falling edge. Directed scenarios add literal expectations, and a randomized
// phase follows them.
module tb_dbg_io_responder;

   localparam int TX_DEPTH = 8;
   localparam int RX_DEPTH = 4;
   localparam int TX_DIV   = 4;

   // ---------------- clock / reset / DUT ----------------
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        s_valid = 1'b0, s_wen = 1'b0;
   logic [63:0] s_addr = '0, s_wdata = '0;
   logic [7:0]  s_wmask = '0;
   logic        s_ready, s_rvalid, tx_valid, rx_ready, exit_valid;
   logic [63:0] s_rdata, exit_code;
   logic [7:0]  tx_data;
   logic        tx_ready = 1'b0, rx_valid = 1'b0;
   logic [7:0]  rx_data = '0;

   always #5 clk = ~clk;

   dbg_io_responder #(
      .DATA_WIDTH(64), .ADDR_WIDTH(64),
      .TX_DEPTH(TX_DEPTH), .RX_DEPTH(RX_DEPTH), .TX_DIV(TX_DIV)
   ) dut (
      .clk(clk), .rst(rst),
      .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr), .s_wen(s_wen),
      .s_wdata(s_wdata), .s_wmask(s_wmask),
      .s_rvalid(s_rvalid), .s_rdata(s_rdata),
      .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
      .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
      .exit_valid(exit_valid), .exit_code(exit_code)
   );

   int n_checks = 0;
   int n_errors = 0;
   bit chk_en   = 1'b0;
   int cur_cyc  = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cur_cyc);
      end
   endtask

   // ---------------- reference model ----------------
   logic [7:0]  tx_q[$];
   logic [7:0]  rx_q[$];
   int          last_hs = -1000;
   bit          m_pend = 0, m_exit = 0, m_rvalid = 0;
   logic [63:0] m_code = '0, m_rdata = '0;

   function automatic bit m_s_ready();
      return (tx_q.size() < TX_DEPTH) && !m_pend;
   endfunction
   function automatic bit m_tx_valid();
      return (tx_q.size() > 0) && ((cur_cyc - last_hs) >= TX_DIV);
   endfunction
   function automatic bit m_exit_valid();
      return m_exit || (m_pend && tx_q.size() == 0);
   endfunction

   // Advance the model by one cycle using the inputs held during that cycle.
   always @(posedge clk) begin
      bit acc, pop, rxp;
      if (!rst) begin
         tx_q.delete(); rx_q.delete();
         last_hs = -1000; m_pend = 0; m_exit = 0; m_code = '0;
         m_rvalid = 0; m_rdata = '0;
      end else begin
         acc = s_valid && m_s_ready();
         pop = m_tx_valid() && tx_ready;
         rxp = rx_valid && (rx_q.size() < RX_DEPTH);
         m_exit   = m_exit_valid();
         m_rvalid = acc;
         m_rdata  = '0;
         if (pop) begin
            void'(tx_q.pop_front());
            last_hs = cur_cyc;
         end
         if (acc && s_wen) begin
            if (s_wdata[63:44] == 20'h01010) tx_q.push_back(s_wdata[7:0]);
            else if (s_wdata[0]) begin m_pend = 1; m_code = s_wdata; end
         end
         if (acc && !s_wen && rx_q.size() > 0) m_rdata = {56'h0, rx_q.pop_front()};
         if (rxp) rx_q.push_back(rx_data);
      end
      cur_cyc++;
   end

   // ---------------- compare process + handshake log ----------------
   logic [7:0] hs_data[$];
   int         hs_cyc[$];
   int         rv_cnt = 0;

   always @(negedge clk) begin
      if (chk_en) begin
         chk("s_ready", s_ready, m_s_ready());
         chk("tx_valid", tx_valid, m_tx_valid());
         if (m_tx_valid()) chk("tx_data", tx_data, tx_q[0]);
         chk("rx_ready", rx_ready, rx_q.size() < RX_DEPTH);
         chk("s_rvalid", s_rvalid, m_rvalid);
         if (m_rvalid) chk("s_rdata", s_rdata, m_rdata);
         chk("exit_valid", exit_valid, m_exit_valid());
         chk("exit_code", exit_code, m_code);
         if (tx_valid && tx_ready) begin
            hs_data.push_back(tx_data);
            hs_cyc.push_back(cur_cyc);
         end
         if (s_rvalid) rv_cnt++;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      rst = 1'b0; s_valid = 1'b0; rx_valid = 1'b0;
      tick();
      rst = 1'b1;
   endtask

   function automatic logic [63:0] pw(input logic [7:0] c);
      return {20'h01010, 36'h0, c};
   endfunction

   // Offer one request and hold it until it is accepted (bounded).
   task automatic send(input logic wen, input logic [63:0] w);
      int n = 0;
      s_valid = 1'b1; s_wen = wen; s_wdata = w;
      s_addr = {$urandom, $urandom}; s_wmask = 8'($urandom);
      while (!s_ready && n < 300) begin tick(); n++; end
      if (!s_ready) chk("send_timeout", 0, 1);
      tick();
      s_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (tx_q.size() != 0 && n < 500) begin tick(); n++; end
      chk("drain_done", tx_q.size() == 0, 1);
   endtask

   task automatic clear_log();
      hs_data.delete(); hs_cyc.delete(); rv_cnt = 0;
   endtask

   task automatic exit_flush(input logic [63:0] code);
      int n = 0;
      do_reset(); clear_log();
      tx_ready = 1'b0;
      for (int i = 0; i < 3; i++) send(1'b1, pw(8'h61 + 8'(i)));
      send(1'b1, code);
      chk("exit_sready_low", s_ready, 0);
      for (int i = 0; i < 5; i++) begin
         chk("exit_held", exit_valid, 0);
         tick();
      end
      tx_ready = 1'b1;
      while (!exit_valid && n < 100) begin tick(); n++; end
      chk("exit_rose", exit_valid, 1);
      chk("exit_after_flush", hs_data.size(), 3);
      chk("exit_code_lit", exit_code, code);
      tick(); tick();
      chk("exit_sticky", exit_valid, 1);
      chk("exit_sready_stuck", s_ready, 0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      do_reset();
      chk_en = 1'b1;
      chk("rst_s_ready", s_ready, 1);
      chk("rst_tx_valid", tx_valid, 0);
      chk("rst_rvalid", s_rvalid, 0);
      chk("rst_rdata", s_rdata, 0);
      chk("rst_exit_valid", exit_valid, 0);
      chk("rst_exit_code", exit_code, 0);

      // Print wrap: ten characters as fast as s_ready permits.
      clear_log();
      tx_ready = 1'b1;
      for (int i = 0; i < 10; i++) send(1'b1, pw(8'h41 + 8'(i)));
      drain();
      tick();
      chk("wrap_count", hs_data.size(), 10);
      chk("wrap_rvalids", rv_cnt, 10);
      for (int i = 0; i < hs_data.size() && i < 10; i++) begin
         chk("wrap_char", hs_data[i], 8'h41 + 8'(i));
         if (i > 0) chk("wrap_gap", hs_cyc[i] - hs_cyc[i-1], 4);
      end

      // Backpressure: eight queued with the sink stalled, the ninth waits.
      do_reset(); clear_log();
      tx_ready = 1'b0;
      for (int i = 0; i < 8; i++) send(1'b1, pw(8'h41 + 8'(i)));
      chk("bp_ready_low", s_ready, 0);
      chk("bp_tx_valid", tx_valid, 1);
      chk("bp_tx_hold", tx_data, 8'h41);
      tick();
      chk("bp_tx_hold2", tx_data, 8'h41);
      s_valid = 1'b1; s_wen = 1'b1; s_wdata = pw(8'h49); tx_ready = 1'b1;
      tick();
      chk("bp_ready_after_pop", s_ready, 1);
      tick();
      s_valid = 1'b0;
      chk("bp_ninth_rvalid", s_rvalid, 1);
      drain();
      tick();
      chk("bp_count", hs_data.size(), 9);
      for (int i = 0; i < hs_data.size() && i < 9; i++)
         chk("bp_char", hs_data[i], 8'h41 + 8'(i));

      // Read path.
      do_reset();
      rx_valid = 1'b1; rx_data = 8'h31; tick();
      rx_data = 8'h32; tick();
      rx_valid = 1'b0;
      send(1'b0, '0); chk("rd_first", s_rdata, 64'h31); chk("rd_first_v", s_rvalid, 1);
      send(1'b0, '0); chk("rd_second", s_rdata, 64'h32);
      send(1'b0, '0); chk("rd_none", s_rdata, 64'h0); chk("rd_none_v", s_rvalid, 1);
      rx_valid = 1'b1;
      for (int i = 0; i < RX_DEPTH; i++) begin rx_data = 8'($urandom); tick(); end
      chk("rx_full_ready", rx_ready, 0);
      rx_valid = 1'b0;
      tick();

      // Exit with flush.
      exit_flush(64'h1);
      exit_flush(64'h2B);

      // Ignored write.
      do_reset(); clear_log();
      send(1'b1, 64'h4);
      chk("ign_rvalid", s_rvalid, 1);
      chk("ign_rdata", s_rdata, 0);
      tick(); tick();
      chk("ign_tx", tx_valid, 0);
      chk("ign_exit", exit_valid, 0);
      chk("ign_ready", s_ready, 1);

      // Reset mid-operation with queued characters and a pending exit.
      tx_ready = 1'b0;
      for (int i = 0; i < 5; i++) send(1'b1, pw(8'h50 + 8'(i)));
      send(1'b1, 64'h7);
      do_reset();
      chk("mid_rst_ready", s_ready, 1);
      chk("mid_rst_tx", tx_valid, 0);
      chk("mid_rst_exit", exit_valid, 0);
      chk("mid_rst_code", exit_code, 0);
      chk("mid_rst_rvalid", s_rvalid, 0);
      chk("mid_rst_rdata", s_rdata, 0);

      // Randomized traffic checked by the model every cycle.
      for (int c = 0; c < 4000; c++) begin
         int k;
         s_valid  = 1'($urandom_range(0, 1));
         s_wen    = 1'($urandom_range(0, 1));
         k        = $urandom_range(0, 99);
         if (k < 65)      s_wdata = pw(8'($urandom));
         else if (k < 67) s_wdata = {$urandom, $urandom} | 64'h1;
         else             s_wdata = {12'h0, 20'($urandom), $urandom} & ~64'h1;
         s_addr   = {$urandom, $urandom};
         s_wmask  = 8'($urandom);
         tx_ready = ($urandom_range(0, 3) != 0);
         rx_valid = 1'($urandom_range(0, 1));
         rx_data  = 8'($urandom);
         rst      = ($urandom_range(0, 149) != 0);
         tick();
      end
      rst = 1'b1; s_valid = 1'b0; rx_valid = 1'b0;
      tick(); tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
